// File: rtl/sc_comp_pkg.sv
// Shared encodings for the single-cycle RV32I core: opcodes, funct fields,
// ALU / writeback / next-PC selector enums and the ALU datapath function.
package sc_comp_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_IMM, WB_PC4, WB_LOAD} wb_sel_e;

  typedef enum logic [1:0] {PC_PLUS4, PC_ALU, PC_JALR, PC_BRANCH} pc_sel_e;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

endpackage

// File: rtl/sc_comp_if.sv
// Byte-addressed 1 KiB memory port: core drives address/write side, memory returns the word.
interface sc_comp_if;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, wdata, be, we, input rdata);
  modport slave  (input addr, wdata, be, we, output rdata);
endinterface

// File: rtl/sc_comp_mem.sv
// 1 KiB little-endian byte array; combinational word read from any byte address,
// byte-enabled write on the clock edge. Addresses wrap modulo 1 KiB.
module sc_comp_mem (
  input logic      clk,
  sc_comp_if.slave bus
);
  logic [7:0] memory [0:1023];

  logic [9:0] w_a1, w_a2, w_a3;
  assign w_a1 = bus.addr + 10'd1;
  assign w_a2 = bus.addr + 10'd2;
  assign w_a3 = bus.addr + 10'd3;

  assign bus.rdata = {memory[w_a3], memory[w_a2], memory[w_a1], memory[bus.addr]};

  // Intentionally no reset: contents are preloaded by backdoor and must survive rst.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      if (bus.be[0]) memory[bus.addr] <= bus.wdata[7:0];
      if (bus.be[1]) memory[w_a1]     <= bus.wdata[15:8];
      if (bus.be[2]) memory[w_a2]     <= bus.wdata[23:16];
      if (bus.be[3]) memory[w_a3]     <= bus.wdata[31:24];
    end
  end
endmodule

// File: rtl/sc_comp_rf.sv
// 32x32 register file, two combinational reads, one synchronous write; x0 hardwired to zero.
module sc_comp_rf (
  input  logic        clk,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic        i_we,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] registers [0:31];

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : registers[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : registers[i_ra2];

  always_ff @(posedge clk) begin
    if (i_we && (i_wa != 5'd0)) registers[i_wa] <= i_wd;
  end
endmodule

// File: rtl/sc_comp.sv
// Single-cycle RV32I computer: fetch, decode, execute, memory and writeback in one clock.
// Define SC_COMP_BYTE_HALF_EN to enable LB/LH/LBU/LHU/SB/SH; otherwise those encodings are NOPs.
module sc_comp
  import sc_comp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] aluout
);
  logic [31:0] r_pc;
  sc_comp_if w_ibus ();
  sc_comp_if w_dbus ();

  logic [31:0] w_instr, w_pc4, w_pc_next, w_wb, w_ld;
  logic [31:0] w_imm, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_alu_a, w_alu_b;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_alt, w_rf_we, w_dm_we, w_a_pc, w_b_imm, w_taken, w_ok;
  logic [3:0]  w_be;
  alu_op_e     w_alu_op;
  wb_sel_e     w_wb_sel;
  pc_sel_e     w_pc_sel;

  assign w_ibus.addr  = {r_pc[9:2], 2'b00};
  assign w_ibus.wdata = 32'd0;
  assign w_ibus.be    = 4'd0;
  assign w_ibus.we    = 1'b0;
  assign w_instr      = w_ibus.rdata;

  sc_comp_mem im (.clk(clk), .bus(w_ibus));
  sc_comp_mem dm (.clk(clk), .bus(w_dbus));

  assign w_opc = w_instr[6:0];
  assign w_rd  = w_instr[11:7];
  assign w_f3  = w_instr[14:12];
  assign w_rs1 = w_instr[19:15];
  assign w_rs2 = w_instr[24:20];
  assign w_alt = (w_instr[31:25] == F7_ALT);

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'd0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  sc_comp_rf rf (
    .clk(clk), .i_ra1(w_rs1), .i_ra2(w_rs2), .i_wa(w_rd), .i_wd(w_wb),
    .i_we(w_rf_we & ~rst), .o_rd1(A), .o_rd2(B)
  );

  always_comb begin
    w_alu_op = ALU_ADD;
    w_wb_sel = WB_ALU;
    w_pc_sel = PC_PLUS4;
    w_imm    = w_imm_i;
    w_a_pc   = 1'b0;
    w_b_imm  = 1'b0;
    w_rf_we  = 1'b0;
    w_dm_we  = 1'b0;
    w_be     = 4'b0000;
    w_ok     = 1'b0;
    case (w_opc)
      OP_LUI:   begin w_imm = w_imm_u; w_wb_sel = WB_IMM; w_rf_we = 1'b1; end
      OP_AUIPC: begin w_imm = w_imm_u; w_a_pc = 1'b1; w_b_imm = 1'b1; w_rf_we = 1'b1; end
      OP_JAL: begin
        w_imm = w_imm_j; w_a_pc = 1'b1; w_b_imm = 1'b1;
        w_wb_sel = WB_PC4; w_rf_we = 1'b1; w_pc_sel = PC_ALU;
      end
      OP_JALR: begin
        w_b_imm = 1'b1; w_wb_sel = WB_PC4; w_rf_we = 1'b1; w_pc_sel = PC_JALR;
      end
      // aluout carries rs1-rs2 for branches; the target uses its own adder.
      OP_BRANCH: begin
        w_alu_op = ALU_SUB;
        w_pc_sel = w_taken ? PC_BRANCH : PC_PLUS4;
      end
      OP_LOAD: begin
        w_ok = (w_f3 == F3_W);
`ifdef SC_COMP_BYTE_HALF_EN
        w_ok = w_ok | (w_f3 == F3_B) | (w_f3 == F3_H) | (w_f3 == F3_BU) | (w_f3 == F3_HU);
`endif
        w_b_imm = 1'b1;
        if (w_ok) begin w_wb_sel = WB_LOAD; w_rf_we = 1'b1; end
      end
      OP_STORE: begin
        w_imm = w_imm_s; w_b_imm = 1'b1;
        if (w_f3 == F3_W) w_be = 4'b1111;
`ifdef SC_COMP_BYTE_HALF_EN
        if (w_f3 == F3_B) w_be = 4'b0001;
        if (w_f3 == F3_H) w_be = 4'b0011;
`endif
        w_dm_we = (w_be != 4'b0000);
      end
      OP_IMM: begin
        w_b_imm = 1'b1; w_rf_we = 1'b1;
        w_alu_op = alu_from_f3(w_f3, (w_f3 == F3_SR) && w_alt);
      end
      OP_OP: begin
        w_rf_we = 1'b1;
        w_alu_op = alu_from_f3(w_f3, w_alt);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_f3)
      F3_BEQ:  w_taken = (A == B);
      F3_BNE:  w_taken = (A != B);
      F3_BLT:  w_taken = ($signed(A) < $signed(B));
      F3_BGE:  w_taken = ($signed(A) >= $signed(B));
      F3_BLTU: w_taken = (A < B);
      F3_BGEU: w_taken = (A >= B);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_alu_a = w_a_pc ? r_pc : A;
  assign w_alu_b = w_b_imm ? w_imm : B;
  assign aluout  = alu(w_alu_op, w_alu_a, w_alu_b);

  assign w_dbus.addr  = aluout[9:0];
  assign w_dbus.wdata = B;
  assign w_dbus.be    = w_be;
  assign w_dbus.we    = w_dm_we & ~rst;

`ifdef SC_COMP_BYTE_HALF_EN
  always_comb begin
    case (w_f3)
      F3_B:    w_ld = {{24{w_dbus.rdata[7]}}, w_dbus.rdata[7:0]};
      F3_H:    w_ld = {{16{w_dbus.rdata[15]}}, w_dbus.rdata[15:0]};
      F3_BU:   w_ld = {24'd0, w_dbus.rdata[7:0]};
      F3_HU:   w_ld = {16'd0, w_dbus.rdata[15:0]};
      default: w_ld = w_dbus.rdata;
    endcase
  end
`else
  assign w_ld = w_dbus.rdata;
`endif

  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    case (w_wb_sel)
      WB_IMM:  w_wb = w_imm;
      WB_PC4:  w_wb = w_pc4;
      WB_LOAD: w_wb = w_ld;
      default: w_wb = aluout;
    endcase
  end

  always_comb begin
    case (w_pc_sel)
      PC_ALU:    w_pc_next = aluout;
      PC_JALR:   w_pc_next = aluout & ~32'd1;
      PC_BRANCH: w_pc_next = r_pc + w_imm_b;
      default:   w_pc_next = w_pc4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= 32'd0;
    else     r_pc <= w_pc_next;
  end
endmodule

// File: tb/tb_sc_comp.sv
// Directed-program bench for sc_comp: backdoor-loaded program, checks at each falling edge.
module tb_sc_comp;
  logic        clk, rst;
  logic [31:0] A, B, aluout;
  int          checks = 0;
  int          errors = 0;

  sc_comp dut (.clk(clk), .rst(rst), .A(A), .B(B), .aluout(aluout));

  sc_comp_if probe ();
  assign probe.addr  = dut.w_dbus.addr;
  assign probe.wdata = dut.w_dbus.wdata;
  assign probe.be    = dut.w_dbus.be;
  assign probe.we    = dut.w_dbus.we;
  assign probe.rdata = dut.w_dbus.rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.im.memory[a + k] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] dword(input int a);
    return {dut.dm.memory[a+3], dut.dm.memory[a+2], dut.dm.memory[a+1], dut.dm.memory[a]};
  endfunction

  logic [7:0] sb_exp;

  initial begin
`ifdef SC_COMP_BYTE_HALF_EN
    sb_exp = 8'h05;
`else
    sb_exp = 8'h00;
`endif
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      dut.im.memory[i] = 8'h00;
      dut.dm.memory[i] = 8'h00;
    end
    for (int i = 0; i < 32; i++) dut.rf.registers[i] = i;
    put(0,  32'h002081B3); // add  x3,x1,x2
    put(4,  32'h00502423); // sw   x5,8(x0)
    put(8,  32'h00802303); // lw   x6,8(x0)
    put(12, 32'h00700013); // addi x0,x0,7
    put(16, 32'h00000073); // ecall (unsupported)
    put(20, 32'h00000463); // beq  x0,x0,8
    put(24, 32'h06300393); // addi x7,x0,99 (skipped)
    put(28, 32'h010000EF); // jal  x1,16
    put(44, 32'h40500433); // sub  x8,x0,x5
    put(48, 32'h40145493); // srai x9,x8,1
    put(52, 32'h00543533); // sltu x10,x8,x5
    put(56, 32'h005425B3); // slt  x11,x8,x5
    put(60, 32'h12345637); // lui  x12,0x12345
    put(64, 32'h00500623); // sb   x5,12(x0)

    #3;
    chk("reset_pc", dut.r_pc, 32'd0);
    chk("add_A", A, 32'd1);
    chk("add_B", B, 32'd2);
    chk("add_aluout", aluout, 32'd3);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("add_x3", dut.rf.registers[3], 32'd3);
    chk("add_pc", dut.r_pc, 32'd4);
    chk("sw_addr", aluout, 32'd8);
    chk("sw_data", B, 32'd5);
    chk("sw_we", {31'd0, probe.we}, 32'd1);
    @(negedge clk);
    chk("sw_mem", dword(8), 32'h00000005);
    chk("lw_pc", dut.r_pc, 32'd8);
    @(negedge clk);
    chk("lw_x6", dut.rf.registers[6], 32'd5);
    @(negedge clk);
    chk("x0_zero", dut.rf.registers[0], 32'd0);
    chk("x0_pc", dut.r_pc, 32'd16);
    @(negedge clk);
    chk("unsup_pc", dut.r_pc, 32'd20);
    chk("beq_aluout", aluout, 32'd0);
    @(negedge clk);
    chk("beq_pc", dut.r_pc, 32'd28);
    chk("beq_skip_x7", dut.rf.registers[7], 32'd7);
    @(negedge clk);
    chk("jal_x1", dut.rf.registers[1], 32'd32);
    chk("jal_pc", dut.r_pc, 32'd44);
    @(negedge clk);
    chk("sub_x8", dut.rf.registers[8], 32'hFFFFFFFB);
    @(negedge clk);
    chk("srai_x9", dut.rf.registers[9], 32'hFFFFFFFD);
    @(negedge clk);
    chk("sltu_x10", dut.rf.registers[10], 32'd0);
    @(negedge clk);
    chk("slt_x11", dut.rf.registers[11], 32'd1);
    @(negedge clk);
    chk("lui_x12", dut.rf.registers[12], 32'h12345000);
    chk("lui_pc", dut.r_pc, 32'd64);
    @(negedge clk);
    chk("sb_mem", {24'd0, dut.dm.memory[12]}, {24'd0, sb_exp});
    chk("sb_pc", dut.r_pc, 32'd68);

    #1 rst = 1'b1;
    #1;
    chk("midrst_pc", dut.r_pc, 32'd0);
    put(0, 32'h010000EF); // jal x1,16
    #1;
    chk("midrst_jal_aluout", aluout, 32'd16);
    chk("midrst_x3", dut.rf.registers[3], 32'd3);
    chk("midrst_x12", dut.rf.registers[12], 32'h12345000);
    chk("midrst_dm", dword(8), 32'h00000005);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("jal0_x1", dut.rf.registers[1], 32'd4);
    chk("jal0_pc", dut.r_pc, 32'd16);

    dut.rf.registers[1] = 32'd77;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_edge_no_write", dut.rf.registers[1], 32'd77);
    chk("rst_edge_pc", dut.r_pc, 32'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
